// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply / restoring divide unit with private HI/LO
// Optional divide-by-zero flag output: define MDU_DIVZERO_FLAG_EN.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       MDUOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
`ifdef MDU_DIVZERO_FLAG_EN
    logic               dz_q, dz_d;
`endif

    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed, a_raw;

    assign op_signed = ~MDUOp[0];
    assign a_mag     = (op_signed && srcA[WIDTH-1]) ? -srcA : srcA;
    assign b_mag     = (op_signed && srcB[WIDTH-1]) ? -srcB : srcB;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign prod_fixed = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo_fixed  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fixed  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign a_raw      = sa_q ? -a_q : a_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
        dz_d     = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_mag;
                    b_d      = b_mag;
                    sa_d     = op_signed & srcA[WIDTH-1];
                    sb_d     = op_signed & srcB[WIDTH-1];
                    is_div_d = MDUOp[1];
                    cnt_d    = CNT_W'(WIDTH);
                    acc_d    = MDUOp[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    state_d  = MDUOp[1] ? S_DIV : S_MUL;
`ifdef MDU_DIVZERO_FLAG_EN
                    dz_d     = 1'b0;
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!is_div_q) begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end else if (b_q == '0) begin
                    // Divide by zero returns the dividend as given, not its magnitude
                    hi_d = a_raw;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end
`ifdef MDU_DIVZERO_FLAG_EN
                dz_d = is_div_q && (b_q == '0);
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MDU_DIVZERO_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
    assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, busy, done;
    logic [1:0]  MDUOp;
    logic [31:0] srcA, srcB, wdata, HI, LO;
`ifdef MDU_DIVZERO_FLAG_EN
    logic        div_zero;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
        .srcA(srcA), .srcB(srcB), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
`ifdef MDU_DIVZERO_FLAG_EN
        , .div_zero(div_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inject > 0: in that busy cycle pulse start with new operands plus hi_we
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int inject, input logic with_we);
        int cyc;
        logic busy_bad;
        logic [31:0] old_hi;
        old_hi = HI;
        @(negedge clk);
        start = 1'b1; MDUOp = op; srcA = a; srcB = b;
        if (with_we) begin hi_we = 1'b1; wdata = 32'hCAFEF00D; end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        if (with_we) chk({tag, "_start_wins"}, HI, old_hi);
        cyc = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (inject > 0 && cyc == inject) begin
                start = 1'b1; MDUOp = 2'b11; srcA = 32'd7; srcB = 32'd9;
                hi_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            if (inject > 0 && cyc == inject + 1) begin
                start = 1'b0; hi_we = 1'b0;
                chk({tag, "_hi_hold"}, HI, old_hi);
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'd34);
        chk({tag, "_busy_window"}, {31'b0, busy_bad}, 32'd0);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_HI"}, HI, eh);
        chk({tag, "_LO"}, LO, el);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic seen;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        MDUOp = 2'b00; srcA = '0; srcB = '0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("rst_dz", {31'b0, div_zero}, 32'd0);
`endif

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1'b0);
        run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 1'b0);
        run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 1'b0);
        run_op("divu_7",    2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0, 1'b0);
        run_op("divu_z",    2'b11, 32'h64,       32'd0,        32'h00000064, 32'hFFFFFFFF, 0, 1'b0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("dz_set", {31'b0, div_zero}, 32'd1);
`endif
        run_op("div_z",     2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 0, 1'b0);
        run_op("mult_dzclr",2'b00, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, 1'b0);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("dz_clr", {31'b0, div_zero}, 32'd0);
`endif

        // MTHI / MTLO while idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk); hi_we = 1'b0;
        chk("mthi", HI, 32'h12345678);
        lo_we = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clk); lo_we = 1'b0;
        chk("mtlo", LO, 32'h9ABCDEF0);
        chk("mthi_keep", HI, 32'h12345678);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both_hi", HI, 32'hA5A5A5A5);
        chk("mt_both_lo", LO, 32'hA5A5A5A5);

        run_op("busy_ign", 2'b01, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 5, 1'b1);

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; MDUOp = 2'b10; srcA = 32'hFFFFFFF9; srcB = 32'd2;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        chk("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", {31'b0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
